// File: rtl/lt_share_arb_pkg.sv
// Shared types and helpers for the time-shared less-than comparator arbiter.
// The compare function is written for reuse by both the RTL and reference models.
package lt_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lt_arb_state_t;

    // Widest operand cmp_lt accepts; callers zero-extend their operands to this width.
    localparam int CMP_MAX_W = 64;

    // Index width for N requesters; never below 1 so N=2 still gets a real bit.
    function automatic int clog2_n(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // a < b after extending each operand by its own signedness, compared as signed.
    function automatic logic cmp_lt(
        input logic [CMP_MAX_W-1:0] a,
        input int                   wa,
        input logic                 sa,
        input logic [CMP_MAX_W-1:0] b,
        input int                   wb,
        input logic                 sb
    );
        logic [CMP_MAX_W-1:0]   mask_a, mask_b;
        logic                   ext_a, ext_b;
        logic signed [CMP_MAX_W:0] ea, eb;
        mask_a = ~({CMP_MAX_W{1'b1}} << wa);
        mask_b = ~({CMP_MAX_W{1'b1}} << wb);
        ext_a  = sa & |(a & ~(mask_a >> 1) & mask_a);
        ext_b  = sb & |(b & ~(mask_b >> 1) & mask_b);
        ea = {ext_a, (a & mask_a) | (~mask_a & {CMP_MAX_W{ext_a}})};
        eb = {ext_b, (b & mask_b) | (~mask_b & {CMP_MAX_W{ext_b}})};
        return ea < eb;
    endfunction

endpackage

// File: rtl/lt_share_arb_pick.sv
// Combinational round-robin picker: first asserted valid at or after ptr, wrapping at N-1.
module rr_pick
    import lt_share_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = clog2_n(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [PW:0] pos;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
            if (!any && valid[pos[PW-1:0]]) begin
                any = 1'b1;
                idx = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/lt_share_arb.sv
// Shares one less-than comparator among N requesters in round-robin order,
// with one comparison in flight and back-to-back issue on the response handshake.
module lt_share_arb
    import lt_share_pkg::*;
#(
    parameter int N           = 2,
    parameter int TDIN0       = 16,
    parameter int TDIN1       = 16,
    parameter bit DIN0_SIGNED = 1'b0,
    parameter bit DIN1_SIGNED = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req_valid,
    output logic [N-1:0]                      req_ready,
    input  logic [N-1:0][TDIN0+TDIN1-1:0]     req_data,
    output logic [N-1:0]                      resp_valid,
    input  logic [N-1:0]                      resp_ready,
    output logic [N-1:0]                      resp_data
);

    localparam int            PW   = clog2_n(N);
    localparam int            TD   = TDIN0 + TDIN1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    lt_arb_state_t     state, state_nxt;
    logic [PW-1:0]     own, ptr, own_inc, pick_ptr, idx;
    logic              res, any, lt, resp_fire, arb_en, grant;
    logic [TD-1:0]     sel_data;

    assign own_inc   = (own == LAST) ? '0 : own + PW'(1);
    assign resp_fire = (state == BUSY) && resp_ready[own];
    assign arb_en    = !rst && ((state == IDLE) || resp_fire);
    // On a response handshake the scan starts just past the finishing owner.
    assign pick_ptr  = (state == BUSY) ? own_inc : ptr;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .any   (any),
        .idx   (idx)
    );

    assign grant    = arb_en && any;
    assign sel_data = req_data[idx];
    assign lt       = cmp_lt(CMP_MAX_W'(sel_data[TDIN0-1:0]), TDIN0, DIN0_SIGNED,
                             CMP_MAX_W'(sel_data[TD-1:TDIN0]), TDIN1, DIN1_SIGNED);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (resp_fire && !grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        if (grant) req_ready[idx] = 1'b1;
        if (!rst && state == BUSY) begin
            resp_valid[own] = 1'b1;
            resp_data[own]  = res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            own <= '0;
            res <= 1'b0;
        end else begin
            if (resp_fire) ptr <= own_inc;
            if (grant) begin
                own <= idx;
                res <= lt;
            end
        end
    end

endmodule
